stopwatch_ctrl: RTL and testbench

//   Run/stop/clear controller between the push-buttons and the 16-bit BCD/hex counter.

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/btn_debounce.sv | 60 ++++++
 rtl/stopwatch_ctrl.sv | 73 +++++++
 tb/tb_stopwatch_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and debounce defaults for stopwatch_ctrl
package stopwatch_pkg;

  localparam logic ST_STOP = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef enum logic {
    STOP = ST_STOP,
    RUN  = ST_RUN
  } state_e;

  localparam int DB_TICKS_DEFAULT = 20;
  localparam int DB_TICKS_SIM     = 4;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser, tick-sampled debounce counter and rising-edge press pulse
module btn_debounce #(
  parameter int DB_TICKS = 20,
  parameter int CNT_W    = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_raw,
  output logic level,
  output logic press_p
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_TICKS - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             lvl_q, lvl_d;
  logic             lvl_dly_q, lvl_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    lvl_d     = lvl_q;
    cnt_d     = cnt_q;
    lvl_dly_d = lvl_q;
    // Any disagreement that does not persist to the last tick restarts the count.
    if (tick) begin
      if (sync2_q == lvl_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        lvl_d = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      lvl_q     <= 1'b0;
      lvl_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_dly_d;
      cnt_q     <= cnt_d;
    end
  end

  assign level   = lvl_q;
  assign press_p = lvl_q & ~lvl_dly_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run/stop/clear FSM and counter gating; CLR_WHILE_RUN_EN lets clear act in RUN
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DB_TICKS = DB_TICKS_DEFAULT,
  parameter int CNT_W    = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_1k,
  input  logic en_in,
  input  logic btn_run,
  input  logic btn_clr,
  output logic count_en,
  output logic count_clr,
  output logic running
);

  state_e state_q, state_d;
  logic   clr_q, clr_d;
  logic   run_p, clr_p;
  logic   clr_ok;

  btn_debounce #(.DB_TICKS(DB_TICKS), .CNT_W(CNT_W)) u_db_run (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick_1k),
    .btn_raw (btn_run),
    .level   (),
    .press_p (run_p)
  );

  btn_debounce #(.DB_TICKS(DB_TICKS), .CNT_W(CNT_W)) u_db_clr (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick_1k),
    .btn_raw (btn_clr),
    .level   (),
    .press_p (clr_p)
  );

  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
`ifdef CLR_WHILE_RUN_EN
    clr_ok  = clr_p;
`else
    clr_ok  = clr_p & (state_q == STOP);
`endif
    // An accepted clear outranks a coincident run/stop press.
    if (clr_ok) begin
      clr_d   = 1'b1;
      state_d = STOP;
    end else if (run_p) begin
      state_d = (state_q == STOP) ? RUN : STOP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= STOP;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  assign count_en  = en_in & (state_q == RUN);
  assign count_clr = clr_q;
  assign running   = (state_q == RUN);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl (DB_TICKS=4, tick every 10 clk, en every 3 clk)
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int EV_RUN_RISE = 1;
  localparam int EV_RUN_FALL = 2;
  localparam int EV_CLR      = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick_1k = 1'b0;
  logic en_in = 1'b0;
  logic btn_run = 1'b0;
  logic btn_clr = 1'b0;
  logic count_en, count_clr, running;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tc = 0;
  int exp_q[$];
  bit mon_en = 1'b0;
  logic prev_run = 1'b0;
  logic prev_clr = 1'b0;

  stopwatch_ctrl #(.DB_TICKS(DB_TICKS_SIM), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1k   (tick_1k),
    .en_in     (en_in),
    .btn_run   (btn_run),
    .btn_clr   (btn_clr),
    .count_en  (count_en),
    .count_clr (count_clr),
    .running   (running)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tc++;
      cyc++;
      tick_1k = (tc % 10 == 0);
      en_in   = (tc % 3 == 0);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_event(input int code);
    int e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL unexpected_event observed=%0d expected=none", code);
    end else begin
      e = exp_q.pop_front();
      chk("event_order", code, e);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (count_clr === 1'b1) begin
        chk("clr_width", int'(prev_clr), 0);
        expect_event(EV_CLR);
      end
      if (running !== prev_run)
        expect_event(running ? EV_RUN_RISE : EV_RUN_FALL);
    end
    prev_clr = count_clr;
    prev_run = running;
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({"drain_", tag}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic press_run(input int hold);
    btn_run = 1'b1;
    wclk(hold);
    btn_run = 1'b0;
  endtask

  task automatic press_clr(input int hold);
    btn_clr = 1'b1;
    wclk(hold);
    btn_clr = 1'b0;
  endtask

  initial begin
    int start, lat, n;

    // Reset with both buttons held high.
    rst = 1'b0;
    btn_run = 1'b1;
    btn_clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_running", int'(running), 0);
      chk("rst_count_clr", int'(count_clr), 0);
      chk("rst_count_en", int'(count_en), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;
    wclk(25);
    // Both debouncers release together, so the clear wins the coincidence.
    exp_q.push_back(EV_CLR);
    drain("post_reset", 100);
    chk("post_reset_running", int'(running), 0);
    btn_run = 1'b0;
    btn_clr = 1'b0;
    wclk(80);

    // Clean press and latency.
    exp_q.push_back(EV_RUN_RISE);
    start = cyc;
    btn_run = 1'b1;
    n = 0;
    while (running !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - start;
    chk("run_latency_in_window", int'(lat >= 30 && lat <= 60), 1);
    wclk(60 - lat);
    btn_run = 1'b0;
    drain("run_on", 100);
    chk("running_on", int'(running), 1);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("count_en_run", int'(count_en), int'(en_in));
    end
    wclk(80);
    exp_q.push_back(EV_RUN_FALL);
    press_run(60);
    drain("run_off", 100);
    chk("running_off", int'(running), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("count_en_stop", int'(count_en), 0);
    end
    wclk(80);

    // Bounce shorter than DB_TICKS ticks never gets through.
    for (int i = 0; i < 8; i++) begin
      btn_run = ~btn_run;
      wclk(25);
    end
    wclk(60);
    chk("bounce_running", int'(running), 0);
    exp_q.push_back(EV_RUN_RISE);
    press_run(60);
    drain("bounce_then_hold", 100);
    chk("bounce_hold_running", int'(running), 1);
    wclk(80);

    // Back to STOP, then clear in STOP.
    exp_q.push_back(EV_RUN_FALL);
    press_run(60);
    drain("stop_again", 100);
    wclk(80);
    exp_q.push_back(EV_CLR);
    press_clr(60);
    drain("clr_stop", 100);
    chk("clr_stop_running", int'(running), 0);
    wclk(80);

    // Clear while running.
    exp_q.push_back(EV_RUN_RISE);
    press_run(60);
    drain("run_for_clr", 100);
    wclk(80);
`ifdef CLR_WHILE_RUN_EN
    exp_q.push_back(EV_CLR);
    exp_q.push_back(EV_RUN_FALL);
    press_clr(60);
    drain("clr_run", 100);
    chk("clr_run_running", int'(running), 0);
    wclk(80);
`else
    press_clr(60);
    wclk(60);
    chk("clr_run_ignored_running", int'(running), 1);
    wclk(80);
    exp_q.push_back(EV_RUN_FALL);
    press_run(60);
    drain("stop_after_ignored_clr", 100);
    wclk(80);
`endif

    // Simultaneous press in STOP.
    exp_q.push_back(EV_CLR);
    btn_run = 1'b1;
    btn_clr = 1'b1;
    wclk(60);
    btn_run = 1'b0;
    btn_clr = 1'b0;
    drain("simultaneous", 100);
    chk("simultaneous_running", int'(running), 0);
    wclk(80);

    // Reset mid-debounce must discard the partial count.
    btn_run = 1'b1;
    wclk(25);
    rst = 1'b0;
    wclk(3);
    rst = 1'b1;
    wclk(22);
    btn_run = 1'b0;
    wclk(100);
    chk("mid_reset_running", int'(running), 0);
    chk("mid_reset_no_pending", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
